// File: rtl/keypad_display_scan_if.sv
// Link between the keypad encoder and the display scanner.
// The encoder side drives the entry state, and the display side drives the LED pins.
interface keypad_display_scan_if;
    logic [11:0] binary;
    logic [1:0]  times;
    logic [4:0]  tries;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;

    modport master (output binary, times, tries, input seg, dig_sel);
    modport slave  (input binary, times, tries, output seg, dig_sel);
endinterface

// File: rtl/keypad_display_scan.sv
// Four-digit multiplexed 7-segment driver for the password-lock keypad.
// Snapshots the entry state once per frame, blanks between digits and blinks during lockout.
module keypad_display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int BLINK_DIV      = 12500000,
    parameter int LOCK_TRIES     = 6,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    keypad_display_scan_if.slave disp
);

    localparam int SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  BLANK_LIM  = SCAN_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [4:0]         LOCK_LIM   = 5'(LOCK_TRIES);
    localparam logic [7:0]         SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0]         DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [11:0]        PASS_CODE  = 12'hBCC;

    logic [SCAN_W-1:0]  scanCnt_q,  scanCnt_d;
    logic [1:0]         idx_q,      idx_d;
    logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
    logic               blinkOn_q,  blinkOn_d;
    logic [11:0]        sBin_q,     sBin_d;
    logic [1:0]         sTimes_q,   sTimes_d;
    logic [4:0]         sTries_q,   sTries_d;
    logic [7:0]         seg_q,      seg_d;
    logic [3:0]         digSel_q,   digSel_d;

    logic       scanWrap;
    logic       locked;
    logic       isPass;
    logic [7:0] segAct;
    logic [3:0] digAct;

    // Active-high glyph codes {dp,g,f,e,d,c,b,a}; A..E are the P/A/S/-/E letters.
    function automatic logic [7:0] glyph(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'h3F;
            4'h1:    g = 8'h06;
            4'h2:    g = 8'h5B;
            4'h3:    g = 8'h4F;
            4'h4:    g = 8'h66;
            4'h5:    g = 8'h6D;
            4'h6:    g = 8'h7D;
            4'h7:    g = 8'h07;
            4'h8:    g = 8'h7F;
            4'h9:    g = 8'h6F;
            4'hA:    g = 8'h73;
            4'hB:    g = 8'h77;
            4'hC:    g = 8'h6D;
            4'hD:    g = 8'h40;
            4'hE:    g = 8'h79;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    always_comb begin
        scanWrap   = (scanCnt_q == SCAN_LAST);
        scanCnt_d  = scanWrap ? '0 : scanCnt_q + 1'b1;
        idx_d      = scanWrap ? idx_q + 2'd1 : idx_q;

        sBin_d     = sBin_q;
        sTimes_d   = sTimes_q;
        sTries_d   = sTries_q;
        if (scanWrap && idx_q == 2'd3) begin
            sBin_d   = disp.binary;
            sTimes_d = disp.times;
            sTries_d = disp.tries;
        end

        // Lockout follows the snapshot, so leaving lockout also waits for a frame boundary.
        locked     = (sTries_q >= LOCK_LIM);
        blinkCnt_d = '0;
        blinkOn_d  = 1'b1;
        if (locked) begin
            if (blinkCnt_q == BLINK_LAST) begin
                blinkCnt_d = '0;
                blinkOn_d  = ~blinkOn_q;
            end else begin
                blinkCnt_d = blinkCnt_q + 1'b1;
                blinkOn_d  = blinkOn_q;
            end
        end
    end

    always_comb begin
        isPass = (sBin_q == PASS_CODE);
        segAct = 8'h00;
        case (idx_q)
            2'd0: segAct = glyph(sBin_q[3:0]);
            2'd1: segAct = glyph(sBin_q[7:4]);
            2'd2: segAct = glyph(sBin_q[11:8]);
            default: begin
                if (isPass)
                    segAct = glyph(4'hA);
                else if (sTries_q == 5'd0)
                    segAct = 8'h00;
                else if (sTries_q <= 5'd9)
                    segAct = glyph(sTries_q[3:0]);
                else
                    segAct = glyph(4'hE);
                segAct[7] = (sTimes_q == 2'd3) && !isPass;
            end
        endcase
        digAct = 4'b0001 << idx_q;

        if ((scanCnt_q < BLANK_LIM) || (locked && !blinkOn_q)) begin
            segAct = 8'h00;
            digAct = 4'h0;
        end

        seg_d    = (SEG_ACTIVE_LOW != 0) ? ~segAct : segAct;
        digSel_d = (DIG_ACTIVE_LOW != 0) ? ~digAct : digAct;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanCnt_q  <= '0;
            idx_q      <= 2'd0;
            blinkCnt_q <= '0;
            blinkOn_q  <= 1'b1;
            sBin_q     <= 12'hFFF;
            sTimes_q   <= 2'd0;
            sTries_q   <= 5'd0;
            seg_q      <= SEG_OFF;
            digSel_q   <= DIG_OFF;
        end else begin
            scanCnt_q  <= scanCnt_d;
            idx_q      <= idx_d;
            blinkCnt_q <= blinkCnt_d;
            blinkOn_q  <= blinkOn_d;
            sBin_q     <= sBin_d;
            sTimes_q   <= sTimes_d;
            sTries_q   <= sTries_d;
            seg_q      <= seg_d;
            digSel_q   <= digSel_d;
        end
    end

    assign disp.seg     = seg_q;
    assign disp.dig_sel = digSel_q;

endmodule

// File: tb/tb_keypad_display_scan.sv
// Directed bench for keypad_display_scan: an active-high and an active-low instance share clk, reset and inputs.
// Expected output per cycle comes from the bench's own cycle count and per-digit glyph tables.
module tb_keypad_display_scan;

    typedef struct {
        logic [11:0] bin;
        logic [1:0]  tms;
        logic [4:0]  tr;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prevExp;
    vec_t vecs [7];

    keypad_display_scan_if busHi ();
    keypad_display_scan_if busLo ();

    keypad_display_scan #(
        .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(64), .LOCK_TRIES(6),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .disp(busHi)
    );

    keypad_display_scan #(
        .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(64), .LOCK_TRIES(6),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dutLow (
        .clk(clk), .rst_n(rst_n), .disp(busLo)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [11:0] bin, input logic [1:0] tms, input logic [4:0] tr);
        busHi.binary = bin;  busHi.times = tms;  busHi.tries = tr;
        busLo.binary = bin;  busLo.times = tms;  busLo.tries = tr;
    endtask

    task automatic compare(input string name, input logic [7:0] seg, input logic [3:0] dig,
                           input logic [7:0] expSeg, input logic [3:0] expDig);
        checks++;
        if (seg !== expSeg || dig !== expDig) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got seg=%h dig=%b want seg=%h dig=%b",
                     name, cyc, seg, dig, expSeg, expDig);
        end
    endtask

    // Output after edge cyc reflects the scan state of count cyc-1 (one register of latency).
    task automatic checkOutput(input string name, input logic [31:0] exp, input bit off);
        int c, scan, idx;
        logic [7:0] expSeg;
        logic [3:0] expDig;
        c    = cyc - 1;
        scan = c % 8;
        idx  = (c / 8) % 4;
        if (off || scan < 2) begin
            expSeg = 8'h00;
            expDig = 4'h0;
        end else begin
            expSeg = exp[8*idx +: 8];
            expDig = 4'b0001 << idx;
        end
        compare({name, "/hi"}, busHi.seg, busHi.dig_sel, expSeg, expDig);
        compare({name, "/lo"}, busLo.seg, busLo.dig_sel, ~expSeg, ~expDig);
    endtask

    task automatic stepClk();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic runCycles(input string name, input int n, input logic [31:0] exp, input bit off);
        for (int i = 0; i < n; i++) begin
            stepClk();
            checkOutput(name, exp, off);
        end
    endtask

    task automatic checkReset(input string name);
        compare({name, "/hi"}, busHi.seg, busHi.dig_sel, 8'h00, 4'h0);
        compare({name, "/lo"}, busLo.seg, busLo.dig_sel, 8'hFF, 4'hF);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{12'hFFF, 2'd0, 5'd0, 32'h00000000};
        vecs[1] = '{12'h246, 2'd3, 5'd0, 32'h805B667D};
        vecs[2] = '{12'hBCC, 2'd3, 5'd0, 32'h73776D6D};
        vecs[3] = '{12'hFFF, 2'd0, 5'd3, 32'h4F000000};
        vecs[4] = '{12'hABD, 2'd1, 5'd1, 32'h06737740};
        vecs[5] = '{12'h135, 2'd3, 5'd5, 32'hED064F6D};
        vecs[6] = '{12'h870, 2'd3, 5'd4, 32'hE67F073F};

        applyStimulus(12'hFFF, 2'd0, 5'd0);
        #1 rst_n = 1'b0;
        #10 checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        prevExp = 32'h0;
        runCycles("startup", 16, prevExp, 1'b0);

        // Each vector lands mid-frame: the old picture must hold until the wrap.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].bin, vecs[v].tms, vecs[v].tr);
            runCycles($sformatf("hold%0d", v), 16, prevExp, 1'b0);
            runCycles($sformatf("vec%0d", v), 48, vecs[v].exp, 1'b0);
            prevExp = vecs[v].exp;
        end

        applyStimulus(12'h246, 2'd0, 5'd6);
        runCycles("lockHold", 16, prevExp, 1'b0);
        runCycles("lockOn1", 64, 32'h7D5B667D, 1'b0);
        runCycles("lockOff", 64, 32'h7D5B667D, 1'b1);
        runCycles("lockOn2", 48, 32'h7D5B667D, 1'b0);

        applyStimulus(12'h246, 2'd0, 5'd0);
        runCycles("unlockHold", 16, 32'h7D5B667D, 1'b0);
        runCycles("unlocked", 48, 32'h005B667D, 1'b0);

        applyStimulus(12'hFFF, 2'd0, 5'd12);
        runCycles("errHold", 16, 32'h005B667D, 1'b0);
        runCycles("errDigit", 36, 32'h79000000, 1'b0);

        rst_n = 1'b0;
        #1 checkReset("midReset");
        stepClk();
        checkReset("midResetHeld");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        runCycles("postReset", 32, 32'h00000000, 1'b0);
        runCycles("postResetErr", 32, 32'h79000000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
